// File: rtl/argmax_compare.sv
// argmax_compare: buffers the layer-2 scores of one image, then scans them one
// entry per clock and reports the index/value of the largest (signed) score.
// Optional feature macro: ARGMAX_MARGIN_EN adds a runner-up tracker and the
// margin output (max minus runner-up).
module argmax_compare #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned IDX_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              score_wr,
  input  logic [DATA_W-1:0] score_data,
  input  logic              compare_en,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  class_idx,
  output logic [DATA_W-1:0] max_score,
  output logic [IDX_W:0]    score_cnt,
  output logic              empty_err
`ifdef ARGMAX_MARGIN_EN
  ,
  output logic [DATA_W:0]   margin
`endif
);

  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_CLASSES);
  localparam logic signed [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic signed [DATA_W-1:0]  score_buf [NUM_CLASSES];
  logic [CNT_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic                      compare_en_q;
  logic signed [DATA_W-1:0]  best_val_q, best_val_d;
  logic [IDX_W-1:0]          best_idx_q, best_idx_d;
  logic                      busy_d, done_d, empty_err_d;
  logic [IDX_W-1:0]          class_idx_d;
  logic [DATA_W-1:0]         max_score_d;
  logic                      wr_ok, start;
  logic [CNT_W-1:0]          cnt_eff;
  logic signed [DATA_W-1:0]  wr_val, rd_val, first_val;
`ifdef ARGMAX_MARGIN_EN
  logic signed [DATA_W-1:0]  second_q, second_d;
  logic [DATA_W:0]           margin_d;
`endif

  // Write qualification, start edge and the effective count including a coincident write
  always_comb begin
    wr_val    = score_data;
    wr_ok     = score_wr && (state_q == S_IDLE) && (wr_ptr_q < FULL_CNT);
    start     = compare_en && !compare_en_q && (state_q == S_IDLE);
    cnt_eff   = wr_ptr_q + CNT_W'(wr_ok);
    rd_val    = score_buf[IDX_W'(rd_ptr_q)];
    first_val = (wr_ok && (wr_ptr_q == '0)) ? wr_val : score_buf[0];
  end

  // Score buffer; contents need no reset
  always_ff @(posedge clk) begin
    if (wr_ok) score_buf[IDX_W'(wr_ptr_q)] <= wr_val;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    best_val_d  = best_val_q;
    best_idx_d  = best_idx_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    empty_err_d = empty_err;
    class_idx_d = class_idx;
    max_score_d = max_score;
`ifdef ARGMAX_MARGIN_EN
    second_d    = second_q;
    margin_d    = margin;
`endif
    case (state_q)
      S_IDLE: begin
        if (wr_ok) wr_ptr_d = cnt_eff;
        if (start) begin
          if (cnt_eff == '0) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            empty_err_d = 1'b1;
            class_idx_d = '0;
            max_score_d = '0;
`ifdef ARGMAX_MARGIN_EN
            margin_d    = '0;
`endif
          end else begin
            state_d    = S_SCAN;
            busy_d     = 1'b1;
            best_val_d = first_val;
            best_idx_d = '0;
            rd_ptr_d   = CNT_W'(1);
`ifdef ARGMAX_MARGIN_EN
            second_d   = MIN_VAL;
`endif
          end
        end
      end
      S_SCAN: begin
        if (rd_ptr_q < wr_ptr_q) begin
          busy_d   = 1'b1;
          rd_ptr_d = rd_ptr_q + CNT_W'(1);
          if (rd_val > best_val_q) begin
            best_val_d = rd_val;
            best_idx_d = IDX_W'(rd_ptr_q);
`ifdef ARGMAX_MARGIN_EN
            second_d   = best_val_q;
          end else if ((rd_val > second_q) || (rd_val == best_val_q)) begin
            second_d   = rd_val;
`endif
          end
        end else begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          class_idx_d = best_idx_q;
          max_score_d = best_val_q;
`ifdef ARGMAX_MARGIN_EN
          margin_d    = {best_val_q[DATA_W-1], best_val_q} - {second_q[DATA_W-1], second_q};
`endif
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        wr_ptr_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      compare_en_q <= 1'b0;
      best_val_q   <= '0;
      best_idx_q   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      empty_err    <= 1'b0;
      class_idx    <= '0;
      max_score    <= '0;
`ifdef ARGMAX_MARGIN_EN
      second_q     <= MIN_VAL;
      margin       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      compare_en_q <= compare_en;
      best_val_q   <= best_val_d;
      best_idx_q   <= best_idx_d;
      busy         <= busy_d;
      done         <= done_d;
      empty_err    <= empty_err_d;
      class_idx    <= class_idx_d;
      max_score    <= max_score_d;
`ifdef ARGMAX_MARGIN_EN
      second_q     <= second_d;
      margin       <= margin_d;
`endif
    end
  end

  assign score_cnt = wr_ptr_q;

endmodule

// File: tb/tb_argmax_compare.sv
// Directed bench for argmax_compare: buffered scores, signed argmax, latency,
// saturation, empty scan, held start level, mid-scan reset, coincident writes.
module tb_argmax_compare;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned IDX_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              score_wr;
  logic [DATA_W-1:0] score_data;
  logic              compare_en;
  logic              busy, done, empty_err;
  logic [IDX_W-1:0]  class_idx;
  logic [DATA_W-1:0] max_score;
  logic [IDX_W:0]    score_cnt;
`ifdef ARGMAX_MARGIN_EN
  logic [DATA_W:0]   margin;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int lat;

  argmax_compare #(.NUM_CLASSES(10), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .score_wr   (score_wr),
    .score_data (score_data),
    .compare_en (compare_en),
    .busy       (busy),
    .done       (done),
    .class_idx  (class_idx),
    .max_score  (max_score),
    .score_cnt  (score_cnt),
    .empty_err  (empty_err)
`ifdef ARGMAX_MARGIN_EN
    ,
    .margin     (margin)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic write_scores(input int vals[$]);
    foreach (vals[i]) begin
      score_wr   = 1'b1;
      score_data = DATA_W'(vals[i]);
      tick();
    end
    score_wr = 1'b0;
  endtask

  // Raise compare_en and wait (bounded) for done; optionally write during SCAN
  task automatic run_scan(input string tag, input int exp_cnt, input bit wr_during,
                          output int latency);
    compare_en = 1'b1;
    tick();
    latency = 1;
    if (wr_during) begin
      score_wr   = 1'b1;
      score_data = DATA_W'(99);
    end else begin
      score_wr = 1'b0;
    end
    check({tag, "_busy"}, int'(busy), (exp_cnt > 0) ? 1 : 0);
    while (!done && latency < 64) begin
      tick();
      latency++;
    end
    score_wr = 1'b0;
    check({tag, "_done"}, int'(done), 1);
    check({tag, "_latency"}, latency, exp_cnt + 1);
  endtask

  // Drop compare_en after done and confirm the pulse ended and the count cleared
  task automatic end_scan(input string tag);
    compare_en = 1'b0;
    tick();
    check({tag, "_done_pulse"}, int'(done), 0);
    check({tag, "_cnt_clear"}, int'(score_cnt), 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    score_wr   = 1'b0;
    score_data = '0;
    compare_en = 1'b0;
    tick();
    tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_idx", int'(class_idx), 0);
    check("rst_max", int'(max_score), 0);
    check("rst_cnt", int'(score_cnt), 0);
    check("rst_err", int'(empty_err), 0);
`ifdef ARGMAX_MARGIN_EN
    check("rst_margin", int'(margin), 0);
`endif
    rst_n = 1'b1;
    tick();

    // T1: tie at 12 keeps lowest index
    write_scores('{5, -3, 12, 7, 0, 12, -1, 3, 9, 2});
    check("t1_cnt", int'(score_cnt), 10);
    run_scan("t1", 10, 1'b0, lat);
    check("t1_idx", int'(class_idx), 2);
    check("t1_max", int'($signed(max_score)), 12);
`ifdef ARGMAX_MARGIN_EN
    check("t1_margin", int'($signed(margin)), 0);
`endif
    end_scan("t1");
    check("t1_idx_held", int'(class_idx), 2);

    // T2: all negative, signed compare
    write_scores('{-9, -10, -11, -12, -13, -14, -15, -16, -17, -18});
    run_scan("t2", 10, 1'b0, lat);
    check("t2_idx", int'(class_idx), 0);
    check("t2_max", int'($signed(max_score)), -9);
`ifdef ARGMAX_MARGIN_EN
    check("t2_margin", int'($signed(margin)), 1);
`endif
    end_scan("t2");

    // T3: buffer saturates at 10, later 100s dropped
    write_scores('{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 100, 100});
    check("t3_cnt_sat", int'(score_cnt), 10);
    run_scan("t3", 10, 1'b0, lat);
    check("t3_idx", int'(class_idx), 9);
    check("t3_max", int'($signed(max_score)), 10);
`ifdef ARGMAX_MARGIN_EN
    check("t3_margin", int'($signed(margin)), 1);
`endif
    end_scan("t3");

    // T4: empty scan
    run_scan("t4", 0, 1'b0, lat);
    check("t4_idx", int'(class_idx), 0);
    check("t4_max", int'(max_score), 0);
    check("t4_err", int'(empty_err), 1);
    end_scan("t4");
    check("t4_err_sticky", int'(empty_err), 1);

    // T6: coincident write included, SCAN-time write ignored
    write_scores('{1, 7, 2});
    score_wr   = 1'b1;
    score_data = DATA_W'(20);
    run_scan("t6", 4, 1'b1, lat);
    check("t6_idx", int'(class_idx), 3);
    check("t6_max", int'($signed(max_score)), 20);
`ifdef ARGMAX_MARGIN_EN
    check("t6_margin", int'($signed(margin)), 13);
`endif
    end_scan("t6");
    check("t6_err_still", int'(empty_err), 1);

    // T5: held level does not restart; mid-scan reset aborts
    write_scores('{3, 8, 1});
    run_scan("t5a", 3, 1'b0, lat);
    check("t5a_idx", int'(class_idx), 1);
    check("t5a_max", int'($signed(max_score)), 8);
    tick();
    write_scores('{4, 2});
    tick();
    tick();
    check("t5_no_restart_busy", int'(busy), 0);
    check("t5_no_restart_done", int'(done), 0);
    check("t5_cnt_held", int'(score_cnt), 2);
    check("t5_idx_held", int'(class_idx), 1);
    compare_en = 1'b0;
    tick();
    compare_en = 1'b1;
    tick();
    check("t5b_busy", int'(busy), 1);
    tick();
    check("t5b_busy2", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_cnt", int'(score_cnt), 0);
    check("t5_rst_err", int'(empty_err), 0);
    check("t5_rst_idx", int'(class_idx), 0);
    tick();
    check("t5_rst_nodone", int'(done), 0);
    compare_en = 1'b0;
    rst_n      = 1'b1;
    tick();
    tick();
    check("t5_after_done", int'(done), 0);
    check("t5_after_busy", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
